buffer_port_master: RTL
=======================

// Module: buffer_port_master
// PURPOSE
// Module-side initiator for the buffer interconnect: turns one burst command into per-cycle
// BufferRAMTEFsizeInputs beats on one module_outputs[] lane, and collects returned read data
// from the matching module_inputs[] lane. It tracks round-trip latency (forward tree, RAM, return tree)
// with a valid shift register. It also emits the slot selects the interconnect needs on both paths.
// PARAMETERS
// STAGE_MODULE  pkg   mux-tree depth; one register stage per level on each path
// RAM_LAT       2     buffer RAM read latency, cycles
// LEN_W         12    width of burst length field
// ADDR_W        32    address width, matches raddr/waddr
// PORTS
// clk        in   1                  clock
// rstn       in   1                  reset, asynchronous, active-low
// cmd_valid  in   1                  burst command valid
// cmd_ready  out  1                  high only in IDLE
// cmd_write  in   1                  1 = write burst, 0 = read burst
// cmd_slot   in   $clog2(SLOT_NUM)   target RAM slot
// cmd_base   in   ADDR_W             first beat address
// cmd_len    in   LEN_W              beat count (0 legal)
// wr_valid   in   1                  write data valid
// wr_ready   out  1                  write data accepted this cycle
// wr_data    in   E*FSIZE            write data
// bus_out    out  BufferRAMTEFsizeInputs   to interconnect module_outputs[i]
// bus_in     in   E*FSIZE            from interconnect module_inputs[i]
// req_slot   out  $clog2(SLOT_NUM)   forward-path slot, aligned with bus_out
// resp_slot  out  $clog2(SLOT_NUM)   return-path slot, aligned with RAM data entering return tree
// rd_valid   out  1                  read beat valid
// rd_data    out  E*FSIZE            read beat data
// busy       out  1                  state != IDLE
// done       out  1                  one-cycle pulse at burst completion
// BEHAVIOUR
// - Reset: state IDLE; bus_out all zero (wren=0); req_slot, resp_slot, rd_data = 0; rd_valid, done, busy = 0.
// - Reset pipelines: valid/slot shift registers cleared. Reset mid-burst discards all in-flight reads.
// - RTT = 2*STAGE_MODULE + RAM_LAT. All outputs are registered.
// - FSM IDLE -> ISSUE -> DRAIN -> IDLE.
// - IDLE: cmd_ready=1. Accept on cmd_valid at edge T; latch write, slot, base, len.
//   If len==0: done pulses at T+1 and state stays IDLE.
// - ISSUE read: beat k drives raddr=base+k, wren=0, one beat per cycle, in cycle T+1+k.
//   No stalls. Enter DRAIN after the last beat.
// - ISSUE write: wr_ready=1 throughout ISSUE.
//   Each cycle with wr_valid issues beat k: waddr=base+k, wdata=wr_data, wren=1. Otherwise bubble (wren=0).
//   Enter DRAIN after the last beat.
// - Non-beat cycles: bus_out fields are 0.
// - Addresses are base+k modulo 2^ADDR_W (wrap allowed).
// - req_slot = latched slot in every ISSUE beat cycle, 0 otherwise.
// - Each read beat pushes 1 into the valid shift register and its slot into the slot shift register.
// - resp_slot = slot tap at STAGE_MODULE+RAM_LAT cycles after issue.
// - rd_valid and rd_data (sampled from bus_in) are asserted RTT+1 cycles after the beat was issued.
//   Beat order is preserved, with no gaps between contiguous issued beats.
// - DRAIN read: done pulses in the same cycle as the last rd_valid, then IDLE.
// - DRAIN write: wait STAGE_MODULE cycles so the last write reaches the RAM, then done pulses, then IDLE.
// - A new command cannot be accepted while busy. The state leaves DRAIN and enters IDLE in the cycle
//   done pulses, so the next command can be accepted one cycle after done.
// TESTING (STAGE_MODULE=3, RAM_LAT=2, RTT=8)
// reset with cmd_valid=1 held -> all outputs zero, cmd_ready=1 once rstn=1, nothing accepted during reset
// read base=0x10 len=4 slot=2 accepted at T0 -> raddr 0x10..0x13 at T1..T4, req_slot=2; rd_valid T10..T13, bus_in data in order; done at T13
// write base=0x40 len=3, wr_valid 1,0,1,1 from T1 -> wren 1,0,1,1 at T1..T4, waddr 0x40,-,0x41,0x42; done at T7
// len=0 command at T0 -> done at T1, busy never 1, bus_out stays zero
// read base=0xFFFFFFFE len=3 -> raddr 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on consecutive cycles
// rstn low at T3 of a len=4 read -> no rd_valid or done afterwards; a fresh read at T6 returns only its own beats

Source files
------------

// File: rtl/buffer_port_master.sv
// Burst initiator for the buffer interconnect: one command -> per-cycle RAM beats, read data collected RTT+1 cycles after issue.
// Beats issue one cycle after acceptance; reads never stall, writes bubble on !wr_valid; cmd_ready only while idle.
package buffer_port_pkg;
    localparam int STAGE_MODULE = 3;
    localparam int SLOT_NUM     = 8;
    localparam int E            = 4;
    localparam int FSIZE        = 8;
    localparam int BUS_ADDR_W   = 32;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] raddr;
        logic [BUS_ADDR_W-1:0] waddr;
        logic [E*FSIZE-1:0]    wdata;
        logic                  wren;
    } BufferRAMTEFsizeInputs;
endpackage

module buffer_port_master #(
    parameter int STAGE_MODULE = buffer_port_pkg::STAGE_MODULE,
    parameter int RAM_LAT      = 2,
    parameter int LEN_W        = 12,
    parameter int ADDR_W       = 32,
    parameter int SLOT_W       = $clog2(buffer_port_pkg::SLOT_NUM),
    parameter int DATA_W       = buffer_port_pkg::E * buffer_port_pkg::FSIZE
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic                                  cmd_write,
    input  logic [SLOT_W-1:0]                     cmd_slot,
    input  logic [ADDR_W-1:0]                     cmd_base,
    input  logic [LEN_W-1:0]                      cmd_len,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [DATA_W-1:0]                     wr_data,
    output buffer_port_pkg::BufferRAMTEFsizeInputs bus_out,
    input  logic [DATA_W-1:0]                     bus_in,
    output logic [SLOT_W-1:0]                     req_slot,
    output logic [SLOT_W-1:0]                     resp_slot,
    output logic                                  rd_valid,
    output logic [DATA_W-1:0]                     rd_data,
    output logic                                  busy,
    output logic                                  done
);
    localparam int RTT      = 2*STAGE_MODULE + RAM_LAT;
    localparam int SLOT_TAP = STAGE_MODULE + RAM_LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state, state_n;
    logic                wr_l;
    logic [SLOT_W-1:0]   slot_l;
    logic [ADDR_W-1:0]   base_l;
    logic [LEN_W-1:0]    len_l;
    logic [LEN_W-1:0]    cnt;
    logic [RTT:0]        vsr;
    logic [SLOT_W-1:0]   ssr [SLOT_TAP+1];
    logic                zlen_pend;
    logic                accept, beat_go, last_beat, drain_done;

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        beat_go    = 1'b0;
        last_beat  = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                accept = cmd_valid && cmd_ready;
                if (accept && cmd_len != '0) state_n = ISSUE;
            end
            ISSUE: begin
                beat_go   = !wr_l || wr_valid;
                last_beat = beat_go && (cnt == len_l - LEN_W'(1));
                if (last_beat) state_n = DRAIN;
            end
            DRAIN: begin
                // Reads finish with the last returned beat; writes just wait out the forward tree.
                drain_done = wr_l ? (cnt == LEN_W'(STAGE_MODULE - 1))
                                  : (vsr[RTT] && vsr[RTT-1:0] == '0);
                if (drain_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign wr_ready  = (state == ISSUE) && wr_l;
    assign busy      = (state != IDLE);
    assign resp_slot = ssr[SLOT_TAP];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_ready <= 1'b0;
            wr_l      <= 1'b0;
            slot_l    <= '0;
            base_l    <= '0;
            len_l     <= '0;
            cnt       <= '0;
            zlen_pend <= 1'b0;
            done      <= 1'b0;
            bus_out   <= '0;
            req_slot  <= '0;
            vsr       <= '0;
            for (int i = 0; i <= SLOT_TAP; i++) ssr[i] <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            cmd_ready <= (state_n == IDLE);
            if (accept) begin
                wr_l   <= cmd_write;
                slot_l <= cmd_slot;
                base_l <= cmd_base;
                len_l  <= cmd_len;
                cnt    <= '0;
            end else if (last_beat || drain_done) begin
                cnt <= '0;
            end else if (beat_go || state == DRAIN) begin
                cnt <= cnt + LEN_W'(1);
            end

            // Zero-length commands never leave IDLE but still owe a done pulse.
            zlen_pend <= accept && (cmd_len == '0);
            done      <= zlen_pend || drain_done;

            bus_out  <= '0;
            req_slot <= '0;
            if (beat_go) begin
                req_slot <= slot_l;
                if (wr_l) begin
                    bus_out.waddr <= base_l + ADDR_W'(cnt);
                    bus_out.wdata <= wr_data;
                    bus_out.wren  <= 1'b1;
                end else begin
                    bus_out.raddr <= base_l + ADDR_W'(cnt);
                end
            end

            vsr    <= {vsr[RTT-1:0], beat_go && !wr_l};
            ssr[0] <= (beat_go && !wr_l) ? slot_l : '0;
            for (int i = 1; i <= SLOT_TAP; i++) ssr[i] <= ssr[i-1];

            rd_valid <= vsr[RTT];
            if (vsr[RTT]) rd_data <= bus_in;
        end
    end
endmodule
